// File: rtl/uart_tx_controller.sv
// uart_tx_controller: memory-mapped 8N1 UART transmitter, LSB first.
//
// Register block at BASE_ADDR (byte offsets):
//   +0x0 DATA   (W)   byte to send, needs tx_be[0]; reads 0
//   +0x4 STATUS (R/W) bit0 busy, bit1 overrun, bit2 int pending,
//                     bit3 parity build; any write clears overrun
//   +0x8 DIV    (R/W) [15:0] bit period in clk cycles, needs tx_be[1:0]=2'b11,
//                     writes of 0/1 ignored, used from the next frame start
//
// Ports:
//   clk, rst_i        clock, synchronous active-high reset
//   tx_addres/tx_wdata/tx_be/we_d2  bus write path (we_d2 from address decoder)
//   out_reg_tx        combinational read data for tx_addres
//   int_fin_tx_i      interrupt-finished vector (bit INT_LINE used)
//   int_req_tx_o      level interrupt request (bit INT_LINE driven)
//   tx_o              serial line, idle high
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11-bit frame).
module uart_tx_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_2000,
  parameter logic [15:0] DEFAULT_DIV = 16'd5208,
  parameter int unsigned INT_LINE    = 2
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [31:0] tx_addres,
  input  logic [31:0] tx_wdata,
  input  logic [3:0]  tx_be,
  input  logic        we_d2,
  input  logic [31:0] int_fin_tx_i,
  output logic [31:0] int_req_tx_o,
  output logic        tx_o,
  output logic [31:0] out_reg_tx
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic PARITY_BUILD = 1'b1;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic PARITY_BUILD = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] period_q, period_d;
  logic [15:0] div_q;
  logic        parity_q, parity_d;
  logic        overrun_q;
  logic        int_q;
  logic        tx_q, tx_d;
  logic        frame_done;
  logic        bit_end;
  logic        busy;

  logic [31:0] offset;
  logic        sel_data, sel_status, sel_div;
  logic        data_wr, status_wr, div_wr;

  assign offset     = tx_addres - BASE_ADDR;
  assign sel_data   = (offset == 32'h0);
  assign sel_status = (offset == 32'h4);
  assign sel_div    = (offset == 32'h8);

  assign data_wr    = we_d2 & sel_data & tx_be[0];
  assign status_wr  = we_d2 & sel_status;
  assign div_wr     = we_d2 & sel_div & (tx_be[1:0] == 2'b11) & (tx_wdata[15:0] > 16'd1);

  assign busy    = (state_q != IDLE);
  assign bit_end = (baud_q == period_q - 16'd1);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    baud_d     = baud_q;
    period_d   = period_q;
    parity_d   = parity_q;
    frame_done = 1'b0;

    if (state_q != IDLE) begin
      baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (data_wr) begin
          state_d  = START;
          shift_d  = tx_wdata[7:0];
          parity_d = ^tx_wdata[7:0];
          bitcnt_d = '0;
          baud_d   = '0;
          period_d = div_q;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d  = {1'b0, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the next state so tx_o comes straight off a flop.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      baud_q    <= '0;
      period_q  <= DEFAULT_DIV;
      div_q     <= DEFAULT_DIV;
      parity_q  <= 1'b0;
      overrun_q <= 1'b0;
      int_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      baud_q   <= baud_d;
      period_q <= period_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      if (div_wr) div_q <= tx_wdata[15:0];
      // A DATA write is dropped whenever a frame is in flight, including
      // the final stop cycle.
      if (data_wr && busy) overrun_q <= 1'b1;
      else if (status_wr)  overrun_q <= 1'b0;
      // Frame completion wins over a coincident int_fin.
      int_q <= frame_done | (int_q & ~int_fin_tx_i[INT_LINE]);
    end
  end

  assign tx_o = tx_q;

  always_comb begin
    int_req_tx_o           = '0;
    int_req_tx_o[INT_LINE] = int_q;
  end

  always_comb begin
    out_reg_tx = '0;
    if (sel_status) out_reg_tx[3:0] = {PARITY_BUILD, int_q, overrun_q, busy};
    if (sel_div)    out_reg_tx[15:0] = div_q;
  end

  logic unused_bits;
  assign unused_bits = ^{tx_wdata[31:16], tx_be[3:2], int_fin_tx_i};

endmodule
